// File: rtl/adder_share_if.sv
// Requester-side bus of adder_share_ctrl: two request/operand channels plus grant and result.
// The subtract selects sub0/sub1 exist only when ADDER_SUB_EN is defined.
interface adder_share_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         cin0;
  logic         cin1;
`ifdef ADDER_SUB_EN
  logic         sub0;
  logic         sub1;
`endif
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;
  logic         done_id;

`ifdef ADDER_SUB_EN
  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1, sub0, sub1,
    input  gnt0, gnt1, busy, sum, cout, done, done_id
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1, sub0, sub1,
    output gnt0, gnt1, busy, sum, cout, done, done_id
  );
`else
  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  gnt0, gnt1, busy, sum, cout, done, done_id
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output gnt0, gnt1, busy, sum, cout, done, done_id
  );
`endif

endinterface

// File: rtl/adder_share_ctrl.sv
// Time-shares one external 4-bit ripple-carry adder between two requesters, one nibble per cycle.
// Optional feature macro: ADDER_SUB_EN (adds sub0/sub1 and a-b mod 2^W subtraction).
module adder_share_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  adder_share_if.slave      bus,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_cin,
  input  logic [3:0]        add_sum,
  input  logic              add_cout
);

  localparam int         W        = 4 * NIBBLES;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] res_r;
  logic [2:0]   idx_r;
  logic         carry_r;
  logic         sub_r;
  logic         owner_r;
  logic         last_r;
  logic         gnt0_r;
  logic         gnt1_r;
  logic         busy_r;
  logic [W-1:0] sum_r;
  logic         cout_r;
  logic         done_r;
  logic         done_id_r;

  logic         take_s;
  logic         win_s;
  logic         sub_s;
  logic [3:0]   b_nib_s;
  logic [W-1:0] res_next_s;

  function automatic logic [3:0] get_nibble(input logic [W-1:0] vec, input logic [2:0] idx);
    get_nibble = 4'(vec >> {idx, 2'b00});
  endfunction

  function automatic logic [W-1:0] put_nibble(input logic [W-1:0] vec, input logic [2:0] idx,
                                              input logic [3:0] nib);
    put_nibble = (vec & ~(W'(4'hF) << {idx, 2'b00})) | (W'(nib) << {idx, 2'b00});
  endfunction

  // Arbitration: a lone request wins; on a tie the requester not served last wins.
  always_comb begin
    take_s = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      win_s = ~last_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`ifdef ADDER_SUB_EN
    sub_s = win_s ? bus.sub1 : bus.sub0;
`else
    sub_s = 1'b0;
`endif
  end

  // Adder drive: current nibble of the latched operands while running, zero otherwise.
  always_comb begin
    b_nib_s = get_nibble(b_r, idx_r);
    if (state_r == RUN) begin
      add_a   = get_nibble(a_r, idx_r);
      add_b   = sub_r ? ~b_nib_s : b_nib_s;
      add_cin = carry_r;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
  end

  // Result with the current nibble's adder sum merged in.
  always_comb begin
    res_next_s = put_nibble(res_r, idx_r, add_sum);
  end

  // Sequencer: accept in IDLE/DONE, walk the nibbles in RUN, publish the result into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      idx_r     <= 3'd0;
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      busy_r    <= 1'b0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
    end else begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (take_s) begin
            a_r     <= win_s ? bus.a1 : bus.a0;
            b_r     <= win_s ? bus.b1 : bus.b0;
            // The carry register doubles as the nibble-0 carry-in; subtraction forces it to 1.
            carry_r <= sub_s ? 1'b1 : (win_s ? bus.cin1 : bus.cin0);
            sub_r   <= sub_s;
            owner_r <= win_s;
            last_r  <= win_s;
            idx_r   <= 3'd0;
            gnt0_r  <= ~win_s;
            gnt1_r  <= win_s;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          res_r   <= res_next_s;
          carry_r <= add_cout;
          if (idx_r == LAST_IDX) begin
            sum_r     <= res_next_s;
            cout_r    <= add_cout;
            done_id_r <= owner_r;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= DONE;
          end else begin
            idx_r   <= idx_r + 3'd1;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_r;
  assign bus.gnt1    = gnt1_r;
  assign bus.busy    = busy_r;
  assign bus.sum     = sum_r;
  assign bus.cout    = cout_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;

endmodule
